// File: rtl/nv_nvdla_sdp_mcif_pkg.sv
// Shared types and field layout for the SDP MCIF read-path responder.
package nv_nvdla_sdp_mcif_pkg;
    localparam int REQ_PD_W = 47;
    localparam int RSP_PD_W = 65;
    localparam int ADDR_LSB = 0;
    localparam int SIZE_LSB = 32;
    localparam int SIZE_W   = 15;
    localparam int MASK_BIT = 64;

    typedef enum logic [1:0] {IDLE, WAIT, STREAM} rd_state_e;
endpackage

// File: rtl/nv_nvdla_sdp_mcif_req_fifo.sv
// Synchronous FIFO with registered full/empty flags; DEPTH must be a power of 2.
module nv_nvdla_sdp_mcif_req_fifo #(
    parameter int W     = 47,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (do_push & ~do_pop)
            cnt_nxt = cnt + 1'b1;
        else if (do_pop & ~do_push)
            cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == FULL_CNT);
            empty <= (cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/nv_nvdla_sdp_mcif_rd_responder.sv
// MCIF-side read responder for SDP MRDMA: queues requests, streams beats from a
// preloadable word memory through a 2-entry skid, and tracks latency-FIFO credits.
module nv_nvdla_sdp_mcif_rd_responder
    import nv_nvdla_sdp_mcif_pkg::*;
#(
    parameter int MEM_AW    = 10,
    parameter int REQ_DEPTH = 4,
    parameter int CDT_DEPTH = 64,
    parameter int RSP_LAT   = 4
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic                sdp2mcif_rd_req_valid,
    output logic                sdp2mcif_rd_req_ready,
    input  logic [REQ_PD_W-1:0] sdp2mcif_rd_req_pd,
    output logic                mcif2sdp_rd_rsp_valid,
    input  logic                mcif2sdp_rd_rsp_ready,
    output logic [RSP_PD_W-1:0] mcif2sdp_rd_rsp_pd,
    input  logic                sdp2mcif_rd_cdt_lat_fifo_pop,
    input  logic                mem_wr_en,
    input  logic [MEM_AW-1:0]   mem_wr_addr,
    input  logic [63:0]         mem_wr_data,
    output logic [15:0]         cdt_cnt,
    output logic                busy,
    output logic                err_cdt_ovf
);
    localparam int LAT_W = $clog2(RSP_LAT);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RSP_LAT - 2);
    localparam logic [15:0]      CDT_MAX  = 16'(CDT_DEPTH);

    logic [63:0]         mem [2**MEM_AW];
    logic [REQ_PD_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                rdy_q;

    rd_state_e           state;
    logic [LAT_W-1:0]    lat_cnt;
    logic [MEM_AW-1:0]   beat_addr;
    logic [SIZE_W-1:0]   beat_rem;
    logic                streaming;
    logic                issue;
    logic                last_beat;
    logic                load_next;

    logic [RSP_PD_W-1:0] skid [2];
    logic                skid_wr;
    logic                skid_rd;
    logic [1:0]          skid_cnt;
    logic                rsp_take;
    logic [RSP_PD_W-1:0] beat_pd;
    logic                unused_bits;

    assign unused_bits = ^{fifo_head[ADDR_LSB +: 3], fifo_head[SIZE_LSB-1:ADDR_LSB+MEM_AW+3]};

    assign sdp2mcif_rd_req_ready = rdy_q & ~fifo_full;
    assign fifo_push = sdp2mcif_rd_req_valid & sdp2mcif_rd_req_ready;

    nv_nvdla_sdp_mcif_req_fifo #(
        .W     (REQ_PD_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk       (nvdla_core_clk),
        .rst       (nvdla_core_rst),
        .push      (fifo_push),
        .push_data (sdp2mcif_rd_req_pd),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) rdy_q <= 1'b0;
        else                rdy_q <= 1'b1;
    end

    // The last WAIT cycle (lat_cnt==0) doubles as the first issue slot so that
    // the first beat lands exactly RSP_LAT cycles after accept.
    assign streaming = (state == STREAM) | ((state == WAIT) & (lat_cnt == '0));
    assign issue     = streaming & (skid_cnt != 2'd2) & (cdt_cnt != '0);
    assign last_beat = (beat_rem == '0);
    assign load_next = ((state == IDLE) | (issue & last_beat)) & ~fifo_empty;
    assign fifo_pop  = load_next;

    // state  | meaning
    // IDLE   | no burst in flight, waiting for a queued request
    // WAIT   | request latched, counting down the response latency
    // STREAM | issuing beats, gated by skid space and credits
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            beat_addr <= '0;
            beat_rem  <= '0;
        end else if (load_next) begin
            state     <= WAIT;
            lat_cnt   <= LAT_INIT;
            beat_addr <= fifo_head[ADDR_LSB+3 +: MEM_AW];
            beat_rem  <= fifo_head[SIZE_LSB +: SIZE_W];
        end else begin
            if (state == WAIT) begin
                if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                else               state   <= STREAM;
            end
            if (issue) begin
                beat_addr <= beat_addr + 1'b1;
                beat_rem  <= beat_rem - 1'b1;
                if (last_beat) state <= IDLE;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    always_comb begin
        beat_pd           = '0;
        beat_pd[MASK_BIT] = 1'b1;
        beat_pd[63:0]     = mem[beat_addr];
    end

    assign rsp_take              = mcif2sdp_rd_rsp_valid & mcif2sdp_rd_rsp_ready;
    assign mcif2sdp_rd_rsp_valid = (skid_cnt != 2'd0);
    assign mcif2sdp_rd_rsp_pd    = skid[skid_rd];

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            skid[0]  <= '0;
            skid[1]  <= '0;
            skid_wr  <= 1'b0;
            skid_rd  <= 1'b0;
            skid_cnt <= 2'd0;
        end else begin
            if (issue) begin
                skid[skid_wr] <= beat_pd;
                skid_wr       <= ~skid_wr;
            end
            if (rsp_take) skid_rd <= ~skid_rd;
            if (issue & ~rsp_take)
                skid_cnt <= skid_cnt + 1'b1;
            else if (rsp_take & ~issue)
                skid_cnt <= skid_cnt - 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            cdt_cnt     <= CDT_MAX;
            err_cdt_ovf <= 1'b0;
        end else begin
            if (issue & ~sdp2mcif_rd_cdt_lat_fifo_pop)
                cdt_cnt <= cdt_cnt - 1'b1;
            else if (sdp2mcif_rd_cdt_lat_fifo_pop & ~issue & (cdt_cnt != CDT_MAX))
                cdt_cnt <= cdt_cnt + 1'b1;
            if (sdp2mcif_rd_cdt_lat_fifo_pop & (cdt_cnt == CDT_MAX))
                err_cdt_ovf <= 1'b1;
        end
    end

    assign busy = ~fifo_empty | (state != IDLE) | (skid_cnt != 2'd0);
endmodule

// File: tb/tb_nv_nvdla_sdp_mcif_rd_responder.sv
// Directed bench for the SDP MCIF read responder with hand-computed expectations.
module tb_nv_nvdla_sdp_mcif_rd_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [46:0] req_pd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [64:0] rsp_pd;
    logic        cdt_pop;
    logic        mem_wr_en;
    logic [9:0]  mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [15:0] cdt_cnt;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stab_viol = 0;
    logic        stall_prev = 1'b0;
    logic [64:0] stall_pd = '0;
    logic [64:0] rx_q[$];
    int          rx_t[$];

    nv_nvdla_sdp_mcif_rd_responder dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rst               (rst),
        .sdp2mcif_rd_req_valid        (req_valid),
        .sdp2mcif_rd_req_ready        (req_ready),
        .sdp2mcif_rd_req_pd           (req_pd),
        .mcif2sdp_rd_rsp_valid        (rsp_valid),
        .mcif2sdp_rd_rsp_ready        (rsp_ready),
        .mcif2sdp_rd_rsp_pd           (rsp_pd),
        .sdp2mcif_rd_cdt_lat_fifo_pop (cdt_pop),
        .mem_wr_en                    (mem_wr_en),
        .mem_wr_addr                  (mem_wr_addr),
        .mem_wr_data                  (mem_wr_data),
        .cdt_cnt                      (cdt_cnt),
        .busy                         (busy),
        .err_cdt_ovf                  (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are captured half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            rx_q.push_back(rsp_pd);
            rx_t.push_back(cyc);
        end
        if (stall_prev && (!rsp_valid || rsp_pd !== stall_pd)) stab_viol <= stab_viol + 1;
        stall_prev <= rsp_valid && !rsp_ready && !rst;
        stall_pd   <= rsp_pd;
    end

    function automatic logic [63:0] pat(input int w);
        logic [9:0] a;
        a = w[9:0];
        return {16'hA5A5, 38'h0, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [31:0] a, input logic [14:0] sz);
        int c = 0;
        req_valid = 1'b1;
        req_pd = {sz, a};
        while (!req_ready && c < 50) begin
            tick();
            c++;
        end
        chk("req_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int limit, input string tag);
        int c = 0;
        while (rx_q.size() < n && c < limit) begin
            tick();
            c++;
        end
        chk(tag, rx_q.size(), n);
    endtask

    task automatic pops(input int n);
        cdt_pop = 1'b1;
        repeat (n) tick();
        cdt_pop = 1'b0;
    endtask

    initial begin
        int k;
        int acc;
        int c;
        logic r;

        rst = 1'b1;
        req_valid = 1'b0;
        req_pd = '0;
        rsp_ready = 1'b0;
        cdt_pop = 1'b0;
        mem_wr_en = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_pd", rsp_pd, 0);
        chk("rst_cdt_cnt", cdt_cnt, 64);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_req_ready", req_ready, 1);

        for (int w = 0; w < 1024; w++) begin
            mem_wr_en = 1'b1;
            mem_wr_addr = w[9:0];
            mem_wr_data = pat(w);
            tick();
        end
        mem_wr_en = 1'b0;

        // Single beat, latency and idle afterwards
        rsp_ready = 1'b1;
        send_req(32'h40, 15'd0);
        k = 1;
        while (!rsp_valid && k < 20) begin
            tick();
            if (!rsp_valid) k++;
        end
        chk("single_latency", k, 4);
        wait_rx(1, 20, "single_count");
        chk("single_pd", rx_q[0], {1'b1, 64'hA5A5_0000_0000_0008});
        repeat (5) tick();
        chk("single_only_one", rx_q.size(), 1);
        chk("single_busy_low", busy, 0);
        chk("single_cdt", cdt_cnt, 63);
        pops(1);
        chk("single_cdt_back", cdt_cnt, 64);

        // Wrapping burst, consecutive beats
        rx_q.delete();
        rx_t.delete();
        send_req(32'h1FF8, 15'd3);
        wait_rx(4, 40, "wrap_count");
        chk("wrap_b0", rx_q[0], {1'b1, pat(10'h3FF)});
        chk("wrap_b1", rx_q[1], {1'b1, pat(0)});
        chk("wrap_b2", rx_q[2], {1'b1, pat(1)});
        chk("wrap_b3", rx_q[3], {1'b1, pat(2)});
        chk("wrap_back_to_back", rx_t[3] - rx_t[0], 3);

        // Offset and upper address bits ignored
        rx_q.delete();
        send_req(32'h8000_0123, 15'd1);
        wait_rx(2, 40, "hiaddr_count");
        chk("hiaddr_b0", rx_q[0], {1'b1, pat(36)});
        chk("hiaddr_b1", rx_q[1], {1'b1, pat(37)});
        repeat (2) tick();
        pops(6);
        chk("cdt_restored_1", cdt_cnt, 64);

        // Credit exhaustion and replenish
        rx_q.delete();
        send_req(32'h320, 15'd99);
        wait_rx(64, 200, "cdt_first64");
        repeat (10) tick();
        chk("cdt_stall_count", rx_q.size(), 64);
        chk("cdt_stall_valid", rsp_valid, 0);
        chk("cdt_stall_zero", cdt_cnt, 0);
        chk("cdt_stall_busy", busy, 1);
        cdt_pop = 1'b1;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (i == 20) chk("cdt_pop_and_issue", cdt_cnt, 1);
        end
        cdt_pop = 1'b0;
        wait_rx(100, 100, "cdt_total");
        repeat (3) tick();
        chk("cdt_end_zero", cdt_cnt, 0);
        for (int j = 0; j < 100; j++)
            chk($sformatf("cdt_beat%0d", j), rx_q[j], {1'b1, pat(100 + j)});
        pops(64);
        chk("cdt_full_again", cdt_cnt, 64);
        chk("cdt_no_err", err, 0);

        // Random backpressure
        rx_q.delete();
        send_req(32'hFA0, 15'd15);
        c = 0;
        while (rx_q.size() < 16 && c < 300) begin
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        rsp_ready = 1'b1;
        wait_rx(16, 20, "bp_count");
        for (int j = 0; j < 16; j++)
            chk($sformatf("bp_beat%0d", j), rx_q[j], {1'b1, pat(500 + j)});
        chk("bp_stable", stab_viol, 0);
        chk("bp_cdt", cdt_cnt, 48);

        // Pop on the exact issue cycle
        rx_q.delete();
        send_req(32'h50, 15'd0);
        tick();
        tick();
        tick();
        cdt_pop = 1'b1;
        tick();
        cdt_pop = 1'b0;
        chk("simul_issued", rsp_valid, 1);
        chk("simul_cdt", cdt_cnt, 48);
        wait_rx(1, 20, "simul_count");
        chk("simul_pd", rx_q[0], {1'b1, pat(10)});
        pops(16);
        chk("cdt_restored_2", cdt_cnt, 64);

        // Request FIFO full with output stalled
        rx_q.delete();
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            req_valid = 1'b1;
            req_pd = {15'd3, 32'((200 + 8 * acc) * 8)};
            r = req_ready;
            tick();
            if (r) acc++;
        end
        chk("full_accepts", acc, 5);
        chk("full_ready_low", req_ready, 0);
        rsp_ready = 1'b1;
        c = 0;
        while (acc < 6 && c < 100) begin
            req_pd = {15'd3, 32'((200 + 8 * acc) * 8)};
            r = req_ready;
            tick();
            if (r) acc++;
            c++;
        end
        req_valid = 1'b0;
        chk("full_all_accepted", acc, 6);
        wait_rx(24, 200, "full_count");
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("full_r%0d_b%0d", i, j), rx_q[4 * i + j], {1'b1, pat(200 + 8 * i + j)});
        pops(24);
        chk("cdt_restored_3", cdt_cnt, 64);

        // Reset in the middle of a burst
        rx_q.delete();
        send_req(32'h960, 15'd15);
        wait_rx(5, 40, "mid_rst_pre");
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_cdt", cdt_cnt, 64);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_no_beat", rx_q.size(), 5);
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_ready", req_ready, 1);
        send_req(32'h38, 15'd0);
        wait_rx(6, 20, "post_rst_count");
        chk("post_rst_pd", rx_q[5], {1'b1, pat(7)});
        repeat (2) tick();
        chk("post_rst_cdt", cdt_cnt, 63);
        pops(1);
        chk("ovf_before", err, 0);
        pops(1);
        chk("ovf_set", err, 1);
        chk("ovf_saturate", cdt_cnt, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
